// File: rtl/bc_horner_seq.sv
// bc_horner_seq: Horner-rule sequencer for the shared X/H/S datapath (rev 1.0).
// Optional macro BC_ABORT_EN adds an ABORT input that cancels a running evaluation.
`default_nettype none

module bc_horner_seq #(
  parameter int MAX_DEGREE = 7,
  parameter int DEG_W      = 4,
  parameter int IDX_W      = 3
) (
  input  logic             clk,
  input  logic             RST,
  input  logic             START,
  input  logic [DEG_W-1:0] DEG,
`ifdef BC_ABORT_EN
  input  logic             ABORT,
`endif
  output logic             LX,
  output logic             LH,
  output logic             LS,
  output logic             SEL_ULA,
  output logic [1:0]       M0,
  output logic [1:0]       M1,
  output logic [1:0]       M2,
  output logic [IDX_W-1:0] COEF_IDX,
  output logic             busy,
  output logic             finished
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LOADX = 3'd1,
    S_INIT  = 3'd2,
    S_MUL   = 3'd3,
    S_ADD   = 3'd4,
    S_DONE  = 3'd5
  } state_t;

  localparam logic [DEG_W-1:0] MAX_DEG_D = DEG_W'(MAX_DEGREE);
  localparam logic [IDX_W-1:0] ONE_IDX   = IDX_W'(1);

  state_t           state_q, state_d;
  logic [IDX_W-1:0] deg_q, deg_d;
  logic [IDX_W-1:0] k_q, k_d;
  logic [DEG_W-1:0] deg_clamped;
  logic             abort_req;

`ifdef BC_ABORT_EN
  assign abort_req = ABORT;
`else
  assign abort_req = 1'b0;
`endif

  assign deg_clamped = (DEG > MAX_DEG_D) ? MAX_DEG_D : DEG;

  always_ff @(posedge clk or negedge RST) begin
    if (!RST) begin
      state_q <= S_IDLE;
      deg_q   <= '0;
      k_q     <= '0;
    end else begin
      state_q <= state_d;
      deg_q   <= deg_d;
      k_q     <= k_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    deg_d    = deg_q;
    k_d      = k_q;
    LX       = 1'b0;
    LH       = 1'b0;
    LS       = 1'b0;
    SEL_ULA  = 1'b0;
    M0       = 2'b00;
    M1       = 2'b00;
    M2       = 2'b00;
    COEF_IDX = '0;
    busy     = 1'b0;
    finished = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (START) begin
          state_d = S_LOADX;
          deg_d   = IDX_W'(deg_clamped);
        end
      end
      S_LOADX: begin
        LX      = 1'b1;
        M2      = 2'b01;
        busy    = 1'b1;
        state_d = S_INIT;
      end
      S_INIT: begin
        LS       = 1'b1;
        M2       = 2'b10;
        COEF_IDX = deg_q;
        busy     = 1'b1;
        if (deg_q == '0) begin
          state_d = S_DONE;
        end else begin
          state_d = S_MUL;
          k_d     = deg_q - ONE_IDX;
        end
      end
      S_MUL: begin
        LH      = 1'b1;
        SEL_ULA = 1'b1;
        busy    = 1'b1;
        state_d = S_ADD;
      end
      S_ADD: begin
        LS       = 1'b1;
        M0       = 2'b10;
        M1       = 2'b10;
        COEF_IDX = k_q;
        busy     = 1'b1;
        // k==0 exits before the decrement, so k never wraps
        if (k_q == '0) begin
          state_d = S_DONE;
        end else begin
          state_d = S_MUL;
          k_d     = k_q - ONE_IDX;
        end
      end
      S_DONE: begin
        finished = 1'b1;
        if (!START) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    if (abort_req && busy) begin
      state_d = S_IDLE;
      deg_d   = '0;
      k_d     = '0;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_bc_horner_seq.sv
// Self-checking bench for bc_horner_seq with a behavioural X/H/S datapath and result scoreboard.
`default_nettype none

module tb_bc_horner_seq;
  localparam int MAX_DEGREE = 7;
  localparam int DEG_W      = 4;
  localparam int IDX_W      = 3;

  logic             clk = 1'b0;
  logic             rst_n = 1'b1;
  logic             start = 1'b0;
  logic [DEG_W-1:0] deg = '0;
`ifdef BC_ABORT_EN
  logic             abort = 1'b0;
`endif
  logic             lx, lh, ls, sel_ula, busy, finished;
  logic [1:0]       m0, m1, m2;
  logic [IDX_W-1:0] coef_idx;
  logic [14:0]      obs;

  int total = 0;
  int bad = 0;
  int exp_q[$];

  int coef[8];
  int x_in = 0;
  int reg_x = 0, reg_h = 0, reg_s = 0;
  int a_op, b_op, alu, src;

  bc_horner_seq #(.MAX_DEGREE(MAX_DEGREE), .DEG_W(DEG_W), .IDX_W(IDX_W)) dut (
    .clk(clk), .RST(rst_n), .START(start), .DEG(deg),
`ifdef BC_ABORT_EN
    .ABORT(abort),
`endif
    .LX(lx), .LH(lh), .LS(ls), .SEL_ULA(sel_ula), .M0(m0), .M1(m1), .M2(m2),
    .COEF_IDX(coef_idx), .busy(busy), .finished(finished)
  );

  always #5 clk = ~clk;

  assign obs = {lx, lh, ls, sel_ula, m0, m1, m2, coef_idx, busy, finished};

  // Behavioural datapath steered only by the controller outputs
  always_comb begin
    a_op = 0;
    b_op = 0;
    case (m0)
      2'b00: a_op = reg_s;
      2'b01: a_op = reg_x;
      2'b10: a_op = reg_h;
      default: a_op = 0;
    endcase
    case (m1)
      2'b00: b_op = reg_x;
      2'b01: b_op = x_in;
      2'b10: b_op = coef[coef_idx];
      default: b_op = reg_h;
    endcase
    alu = sel_ula ? a_op * b_op : a_op + b_op;
    case (m2)
      2'b00: src = alu;
      2'b01: src = x_in;
      2'b10: src = coef[coef_idx];
      default: src = 0;
    endcase
  end

  always @(posedge clk) begin
    if (lx) reg_x <= src;
    if (lh) reg_h <= src;
    if (ls) reg_s <= src;
  end

  // Expected output vector per state code (0 IDLE .. 5 DONE)
  function automatic logic [14:0] exp_vec(input int st, input int idx);
    logic [IDX_W-1:0] i;
    logic [14:0] v;
    i = idx[IDX_W-1:0];
    case (st)
      1: v = {1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 2'b01, 3'd0, 1'b1, 1'b0};
      2: v = {1'b0, 1'b0, 1'b1, 1'b0, 2'b00, 2'b00, 2'b10, i,    1'b1, 1'b0};
      3: v = {1'b0, 1'b1, 1'b0, 1'b1, 2'b00, 2'b00, 2'b00, 3'd0, 1'b1, 1'b0};
      4: v = {1'b0, 1'b0, 1'b1, 1'b0, 2'b10, 2'b10, 2'b00, i,    1'b1, 1'b0};
      5: v = {1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 2'b00, 3'd0, 1'b0, 1'b1};
      default: v = '0;
    endcase
    return v;
  endfunction

  function automatic int horner(input int d, input int x);
    int acc;
    acc = coef[d];
    for (int j = d - 1; j >= 0; j--) acc = acc * x + coef[j];
    return acc;
  endfunction

  // Step s after the START edge: 0 LOADX, 1 INIT, then MUL/ADD pairs, then DONE
  function automatic int step_state(input int s, input int dc);
    if (s == 0) return 1;
    if (s == 1) return 2;
    if (s >= 2 + 2 * dc) return 5;
    return ((s - 2) % 2 == 0) ? 3 : 4;
  endfunction

  function automatic int step_idx(input int s, input int dc);
    if (s == 1) return dc;
    if (s >= 2 && s < 2 + 2 * dc && (s - 2) % 2 == 1) return dc - 1 - (s - 2) / 2;
    return 0;
  endfunction

  task automatic test_reset();
    #1 rst_n = 1'b0;
    repeat (2) @(negedge clk);
    total++;
    if (obs !== 15'd0) begin
      bad++;
      $display("FAIL reset_outputs: got %h want %h", obs, 15'd0);
    end
    rst_n = 1'b1;
    repeat (2) begin
      @(negedge clk);
      total++;
      if (obs !== 15'd0) begin
        bad++;
        $display("FAIL reset_idle: got %h want %h", obs, 15'd0);
      end
    end
  endtask

  task automatic test_operation(input string name, input int d_req, input int x, input int hold);
    int dc, nsteps, st, got_s;
    dc = (d_req > MAX_DEGREE) ? MAX_DEGREE : d_req;
    nsteps = 2 + 2 * dc;
    x_in = x;
    exp_q.push_back(horner(dc, x));
    @(negedge clk);
    start = 1'b1;
    deg = DEG_W'(d_req);
    for (int s = 0; s <= nsteps; s++) begin
      @(negedge clk);
      if (s == 0) deg = DEG_W'($urandom);
      st = step_state(s, dc);
      total++;
      if (obs !== exp_vec(st, step_idx(s, dc))) begin
        bad++;
        $display("FAIL %s step%0d: got %h want %h", name, s, obs, exp_vec(st, step_idx(s, dc)));
      end
    end
    total++;
    if (exp_q.size() == 0) begin
      bad++;
      $display("FAIL %s scoreboard: got result with empty queue", name);
    end else begin
      got_s = exp_q.pop_front();
      if (reg_s !== got_s) begin
        bad++;
        $display("FAIL %s result: got %0d want %0d", name, reg_s, got_s);
      end
    end
    for (int h = 0; h < hold; h++) begin
      @(negedge clk);
      total++;
      if (obs !== exp_vec(5, 0)) begin
        bad++;
        $display("FAIL %s hold%0d: got %h want %h", name, h, obs, exp_vec(5, 0));
      end
    end
    start = 1'b0;
    @(negedge clk);
    total++;
    if (obs !== 15'd0) begin
      bad++;
      $display("FAIL %s release: got %h want %h", name, obs, 15'd0);
    end
  endtask

  task automatic test_deg0();
    coef[0] = 3;
    test_operation("deg0", 0, 5, 0);
    total++;
    if (reg_s !== 3) begin
      bad++;
      $display("FAIL deg0_value: got %0d want 3", reg_s);
    end
  endtask

  task automatic test_deg2();
    coef[0] = 4; coef[1] = 3; coef[2] = 2;
    test_operation("deg2", 2, 5, 0);
    total++;
    if (reg_s !== 69) begin
      bad++;
      $display("FAIL deg2_value: got %0d want 69", reg_s);
    end
  endtask

  task automatic test_clamp();
    for (int j = 0; j < 8; j++) coef[j] = int'($urandom_range(0, 9));
    test_operation("clamp", 9, 2, 0);
  endtask

  task automatic test_handshake();
    coef[0] = 7; coef[1] = 6;
    test_operation("handshake", 1, 4, 5);
  endtask

  task automatic test_back_to_back();
    for (int n = 0; n < 4; n++) begin
      for (int j = 0; j < 8; j++) coef[j] = int'($urandom_range(0, 20));
      test_operation("b2b", int'($urandom_range(0, 9)), int'($urandom_range(1, 6)), int'($urandom_range(0, 2)));
    end
  endtask

  task automatic test_reset_mid();
    bit seen;
    seen = 1'b0;
    coef[0] = 1; coef[1] = 1; coef[2] = 1;
    x_in = 2;
    @(negedge clk);
    start = 1'b1;
    deg = 4'd2;
    for (int c = 0; c < 20 && !seen; c++) begin
      @(negedge clk);
      if (lh === 1'b1) seen = 1'b1;
    end
    total++;
    if (!seen) begin
      bad++;
      $display("FAIL reset_mid_wait: got no MUL within 20 cycles want LH=1");
    end
    rst_n = 1'b0;
    start = 1'b0;
    #1;
    total++;
    if (obs !== 15'd0) begin
      bad++;
      $display("FAIL reset_mid_async: got %h want %h", obs, 15'd0);
    end
    #2 rst_n = 1'b1;
    repeat (3) begin
      @(negedge clk);
      total++;
      if (obs !== 15'd0) begin
        bad++;
        $display("FAIL reset_mid_idle: got %h want %h", obs, 15'd0);
      end
    end
  endtask

`ifdef BC_ABORT_EN
  task automatic test_abort();
    int got_s;
    for (int j = 0; j < 4; j++) coef[j] = j + 2;
    x_in = 3;
    @(negedge clk);
    start = 1'b1;
    deg = 4'd3;
    for (int s = 0; s <= 4; s++) begin
      @(negedge clk);
      total++;
      if (obs !== exp_vec(step_state(s, 3), step_idx(s, 3))) begin
        bad++;
        $display("FAIL abort_pre step%0d: got %h want %h", s, obs, exp_vec(step_state(s, 3), step_idx(s, 3)));
      end
    end
    abort = 1'b1;
    start = 1'b0;
    repeat (2) begin
      @(negedge clk);
      total++;
      if (obs !== 15'd0) begin
        bad++;
        $display("FAIL abort_idle: got %h want %h", obs, 15'd0);
      end
    end
    exp_q.push_back(horner(3, 3));
    start = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    total++;
    if (obs !== exp_vec(1, 0)) begin
      bad++;
      $display("FAIL abort_start_prio: got %h want %h", obs, exp_vec(1, 0));
    end
    for (int s = 1; s <= 8; s++) begin
      @(negedge clk);
      total++;
      if (obs !== exp_vec(step_state(s, 3), step_idx(s, 3))) begin
        bad++;
        $display("FAIL abort_rerun step%0d: got %h want %h", s, obs, exp_vec(step_state(s, 3), step_idx(s, 3)));
      end
    end
    got_s = exp_q.pop_front();
    total++;
    if (reg_s !== got_s) begin
      bad++;
      $display("FAIL abort_rerun_result: got %0d want %0d", reg_s, got_s);
    end
    start = 1'b0;
    @(negedge clk);
  endtask
`endif

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_deg0();
    test_deg2();
    test_clamp();
    test_handshake();
    test_back_to_back();
    test_reset_mid();
`ifdef BC_ABORT_EN
    test_abort();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
